// File: rtl/traffic_light_ctrl_if.sv
// traffic_light_ctrl_if: timebase tick, demand inputs and lamp/status outputs of the phase controller
interface traffic_light_ctrl_if;
    logic       TC_TIMEBASE;
    logic       SIDE_REQ;
    logic       NIGHT;
    logic       MAIN_R;
    logic       MAIN_Y;
    logic       MAIN_G;
    logic       SIDE_R;
    logic       SIDE_Y;
    logic       SIDE_G;
    logic       PED_WALK;
    logic [2:0] PHASE;
    modport master (
        output TC_TIMEBASE, SIDE_REQ, NIGHT,
        input  MAIN_R, MAIN_Y, MAIN_G, SIDE_R, SIDE_Y, SIDE_G, PED_WALK, PHASE
    );
    modport slave (
        input  TC_TIMEBASE, SIDE_REQ, NIGHT,
        output MAIN_R, MAIN_Y, MAIN_G, SIDE_R, SIDE_Y, SIDE_G, PED_WALK, PHASE
    );
endinterface

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: tick-timed main/side road phase sequencer with demand latch, walk lamp and night flash
module traffic_light_ctrl #(
    parameter int T_MG_MIN = 20,
    parameter int T_Y      = 3,
    parameter int T_AR     = 1,
    parameter int T_SG     = 10,
    parameter int CNT_W    = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    traffic_light_ctrl_if.slave    bus
);
    typedef enum logic [2:0] {
        MG    = 3'd0,
        MY    = 3'd1,
        AR1   = 3'd2,
        SG    = 3'd3,
        SY    = 3'd4,
        AR2   = 3'd5,
        FLASH = 3'd6
    } state_e;

    localparam logic [CNT_W-1:0] MG_END = CNT_W'(T_MG_MIN - 1);
    localparam logic [CNT_W-1:0] Y_END  = CNT_W'(T_Y - 1);
    localparam logic [CNT_W-1:0] AR_END = CNT_W'(T_AR - 1);
    localparam logic [CNT_W-1:0] SG_END = CNT_W'(T_SG - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, last;
    logic               req_q, req_d, flash_q, flash_d;
    logic               tick, night, done;

    assign tick  = bus.TC_TIMEBASE;
    assign night = bus.NIGHT;
    assign last  = (state_q == MY || state_q == SY) ? Y_END :
                   (state_q == SG) ? SG_END :
                   (state_q == MG) ? MG_END : AR_END;
    assign done  = tick && cnt_q == last;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= AR2;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            flash_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            flash_q <= flash_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flash_d = flash_q;
        case (state_q)
            MG:      state_d = (done && (req_q || night)) ? MY : MG;
            MY:      state_d = done ? AR1 : MY;
            AR1:     state_d = done ? (night ? FLASH : SG) : AR1;
            SG:      state_d = done ? SY : SG;
            SY:      state_d = done ? AR2 : SY;
            AR2:     state_d = done ? (night ? FLASH : MG) : AR2;
            FLASH: begin
                state_d = (tick && !night) ? AR2 : FLASH;
                flash_d = flash_q ^ tick;
            end
            default: state_d = AR2;
        endcase
        // MG saturates at its last count; FLASH timing is carried by flash_q alone
        if (tick && cnt_q != last && state_q != FLASH)
            cnt_d = cnt_q + CNT_W'(1);
        if (state_d != state_q) begin
            cnt_d   = '0;
            flash_d = 1'b0;
        end
        req_d = (state_d == SG) ? 1'b0 : (req_q | (bus.SIDE_REQ && state_q != SG));
    end

    assign bus.PHASE    = state_q;
    assign bus.MAIN_G   = state_q == MG;
    assign bus.MAIN_Y   = state_q == MY || (state_q == FLASH && flash_q);
    assign bus.MAIN_R   = !(state_q == MG || state_q == MY || state_q == FLASH);
    assign bus.SIDE_G   = state_q == SG;
    assign bus.SIDE_Y   = state_q == SY || (state_q == FLASH && flash_q);
    assign bus.SIDE_R   = !(state_q == SG || state_q == SY || state_q == FLASH);
    assign bus.PED_WALK = state_q == SG;
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl: scoreboard bench driving ticks/demand/night and comparing phase and lamps every cycle
module tb_traffic_light_ctrl;
    localparam int T_MG_MIN = 4;
    localparam int T_Y      = 2;
    localparam int T_AR     = 1;
    localparam int T_SG     = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    traffic_light_ctrl_if bus();

    traffic_light_ctrl #(
        .T_MG_MIN(T_MG_MIN), .T_Y(T_Y), .T_AR(T_AR), .T_SG(T_SG), .CNT_W(8)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    string       scen  = "init";
    logic [9:0]  exp_q[$];
    int          m_st  = 5;
    int          m_cnt = 0;
    bit          m_req = 1'b0;
    bit          m_fb  = 1'b0;

    task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %b required %b (phase,MR,MY,MG,SR,SY,SG,WALK)", tag, got, exp);
        end
    endtask

    function automatic int dur(input int s);
        return (s == 1 || s == 4) ? T_Y : (s == 3) ? T_SG : (s == 0) ? T_MG_MIN : T_AR;
    endfunction

    function automatic logic [9:0] expv(input int s, input bit fb);
        logic [6:0] l;
        case (s)
            0:       l = 7'b0011000;
            1:       l = 7'b0101000;
            3:       l = 7'b1000011;
            4:       l = 7'b1000100;
            6:       l = {1'b0, fb, 2'b00, fb, 2'b00};
            default: l = 7'b1001000;
        endcase
        return {3'(s), l};
    endfunction

    task automatic model(input bit t, input bit r, input bit n, input bit rs);
        int ns;
        bit nreq;
        if (rs) begin
            m_st = 5; m_cnt = 0; m_req = 1'b0; m_fb = 1'b0;
            return;
        end
        ns   = m_st;
        nreq = m_req | (r && m_st != 3);
        if (t) begin
            if (m_st == 6) begin
                if (!n) ns = 5;
                else m_fb = !m_fb;
            end else if (m_cnt < dur(m_st) - 1) m_cnt++;
            else if (m_st == 0) begin
                if (m_req || n) ns = 1;
            end else ns = (m_st == 1) ? 2 : (m_st == 3) ? 4 : (m_st == 4) ? 5 : n ? 6 : (m_st == 2) ? 3 : 0;
        end
        if (ns != m_st) begin
            m_cnt = 0;
            m_fb  = 1'b0;
            if (ns == 3) nreq = 1'b0;
        end
        m_st  = ns;
        m_req = nreq;
    endtask

    task automatic cyc(input bit t, input bit r, input bit n, input bit rs);
        bus.TC_TIMEBASE = t;
        bus.SIDE_REQ    = r;
        bus.NIGHT       = n;
        rst             = rs;
        model(t, r, n, rs);
        exp_q.push_back(expv(m_st, m_fb));
        @(negedge clk);
        chk(scen, {bus.PHASE, bus.MAIN_R, bus.MAIN_Y, bus.MAIN_G, bus.SIDE_R, bus.SIDE_Y, bus.SIDE_G, bus.PED_WALK},
            exp_q.pop_front());
    endtask

    task automatic tk(input bit r, input bit n);
        repeat (3) cyc(1'b0, r, n, 1'b0);
        cyc(1'b1, r, n, 1'b0);
    endtask

    initial begin
        int g;
        bit n;
        bus.TC_TIMEBASE = 1'b0;
        bus.SIDE_REQ    = 1'b0;
        bus.NIGHT       = 1'b0;
        scen = "reset";
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        scen = "mg_hold";
        repeat (21) tk(1'b0, 1'b0);
        scen = "req_pulse";
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (14) tk(1'b0, 1'b0);
        scen = "req_held";
        repeat (30) tk(1'b1, 1'b0);
        scen = "night";
        repeat (12) tk(1'b0, 1'b1);
        scen = "day";
        repeat (4) tk(1'b0, 1'b0);
        scen = "rst_sg";
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        g = 0;
        while (m_st != 3 && g < 50) begin
            tk(1'b0, 1'b0);
            g++;
        end
        chk("reach_sg", {7'd0, bus.PHASE}, 10'd3);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("rst_in_sg", {7'd0, bus.PHASE}, 10'd5);
        repeat (4) tk(1'b0, 1'b0);
        scen = "b2b_sy";
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        g = 0;
        while (m_st != 4 && g < 50) begin
            tk(1'b0, 1'b0);
            g++;
        end
        chk("reach_sy", {7'd0, bus.PHASE}, 10'd4);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("sy_to_ar2", {7'd0, bus.PHASE}, 10'd5);
        scen = "random";
        n = 1'b0;
        repeat (600) begin
            if ($urandom_range(0, 39) == 0) n = !n;
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, n, $urandom_range(0, 199) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Intersection phase controller that sits directly downstream of the clock-enable/timebase stage and consumes its single-cycle TC_TIMEBASE tick. It sequences a main road and a side road through green/yellow/all-red phases whose durations are counted in timebase ticks. A latched side-road demand, a pedestrian walk indication and a night-mode flashing-yellow state are included. The lamp outputs drive the top-level light drivers directly.

## Interface
- T_MG_MIN, 20: minimum main-green duration, ticks (≥1)
- T_Y, 3: yellow duration, both roads, ticks (≥1)
- T_AR, 1: all-red clearance duration, ticks (≥1)
- T_SG, 10: side-green duration, ticks (≥1)
- CNT_W, 8: phase counter width; every duration parameter ≤ 2^CNT_W
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- TC_TIMEBASE  in  1  one-CLK-wide timebase pulse from the clock-enable stage
- SIDE_REQ  in  1  side-road vehicle/pedestrian demand, level or pulse, synchronous to CLK
- NIGHT  in  1  night-mode request, level
- MAIN_R, MAIN_Y, MAIN_G  out  1 each  main-road lamps
- SIDE_R, SIDE_Y, SIDE_G  out  1 each  side-road lamps
- PED_WALK  out  1  pedestrian walk lamp, side crossing
- PHASE  out  3  current state code, for debug/status

## Operation
- States and PHASE codes: MG=0, MY=1, AR1=2, SG=3, SY=4, AR2=5, FLASH=6. Code 7 is illegal and recovers to AR2 with CNT=0 on the next edge.
- Moore outputs, decoded from the state register only:
  - MG: MAIN_G, SIDE_R
  - MY: MAIN_Y, SIDE_R
  - AR1/AR2: MAIN_R, SIDE_R
  - SG: MAIN_R, SIDE_G, PED_WALK
  - SY: MAIN_R, SIDE_Y
  - FLASH: MAIN_Y=SIDE_Y=FLASH_BIT, all other lamps 0
- CNT (CNT_W bits) counts TC_TIMEBASE pulses in the current state. It is cleared to 0 on every state transition and only changes on a tick.
- Timed exit from MY, AR1, SG, SY, AR2 happens on the tick where CNT == T_x−1; that tick is the T_x-th tick in the state.
  - MY→AR1
  - SG→SY
  - SY→AR2
  - AR1→SG, or AR1→FLASH if NIGHT=1 on that tick
  - AR2→MG, or AR2→FLASH if NIGHT=1 on that tick
- MG: CNT saturates at T_MG_MIN−1. MG→MY on a tick when CNT == T_MG_MIN−1 and either REQ_PEND=1 or NIGHT=1. Otherwise main green is held indefinitely.
- REQ_PEND: internal flag.
  - Set on any cycle with SIDE_REQ=1 while the state is not SG.
  - Cleared on the edge that enters SG; the clear takes priority over a set on that same edge.
  - SIDE_REQ during SG is ignored.
- FLASH: FLASH_BIT toggles on every tick and is 0 on entry. On a tick with NIGHT=0, go to AR2 with CNT=0 and FLASH_BIT=0. NIGHT is otherwise sampled only on ticks.
- A green lamp is never adjacent to a green or flashing state without an intervening yellow and all-red. No other transitions exist.

## Timing
- Reset, synchronous and active-high: state=AR2, CNT=0, REQ_PEND=0, FLASH_BIT=0.
  - Outputs during and after reset: MAIN_R=1, SIDE_R=1, all other lamps 0, PED_WALK=0, PHASE=5.
  - RST mid-phase overrides any tick on the same edge; the first MG begins T_AR ticks after RST is released.
- Latency: the state, CNT and outputs update on the CLK edge that samples TC_TIMEBASE=1. The new lamps are visible in the cycle following the tick.
- No state change ever occurs in a cycle without a tick, except reset and illegal-state recovery.
- The block is agnostic to tick spacing, so TESTMODE acceleration upstream only compresses wall-clock time.
- Back-to-back ticks on consecutive cycles are legal, and each one counts.

## Test plan
Parameters for all scenarios: T_MG_MIN=4, T_Y=2, T_AR=1, T_SG=3; tick every 4 CLKs unless stated.
- Reset release, SIDE_REQ=0, NIGHT=0 -> PHASE=5 with both reds until the 1st tick, then PHASE=0 (MG). The block stays in MG through 20 ticks with CNT saturated at 3.
- SIDE_REQ pulsed for 1 CLK at tick 1 of MG -> MY after the 4th MG tick, then AR1 after 2 ticks, SG after 1, SY after 3, AR2 after 2, MG after 1. PED_WALK=1 exactly during SG. REQ_PEND=0 on returning to MG.
- SIDE_REQ held high through an entire cycle -> REQ_PEND re-sets immediately after SG ends, and MG lasts exactly 4 ticks every cycle.
- NIGHT=1 asserted during MG with no request -> MG exits on its 4th tick, then MY, then AR1, then FLASH. MAIN_Y and SIDE_Y toggle per tick, starting at 0. Deassert NIGHT -> AR2 on the next tick, then MG one tick later.
- RST pulsed for 1 CLK during SG, coincident with a tick -> PHASE=5, lamps both red, PED_WALK=0 on the next cycle, and no SY is emitted.
- Ticks on consecutive CLKs in SY with T_Y=2 -> SY lasts exactly 2 CLKs and then goes to AR2.
